circ_smpl_queue: RTL and testbench

//  Parametrised circular sample queue: next generation of the scope capture

---
 rtl/circq_pkg.sv | 21 ++
 rtl/circq_ram.sv | 35 +++
 rtl/circ_smpl_queue.sv | 158 +++++++++++++++
 tb/tb_circ_smpl_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/circq_pkg.sv
// Shared types and width helpers for the circular sample queue.
// Optional decimation front-end is enabled with CIRCQ_DECIM_EN.
// Pointer and fill widths are derived from the DEPTH parameter via $clog2.
package circq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } circq_state_t;

  // Pointer width: enough bits to address DEPTH entries (at least 1)
  function automatic int circq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Fill width: must represent 0..DEPTH inclusive
  function automatic int circq_fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/circq_ram.sv
// DEPTH x WIDTH register file: one write port, one registered read port.
// Read data appears the cycle after re; same-edge write to the read address is forwarded.
// No flow control; the owner decides when to read and write.
module circq_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array: deliberately not reset, stale contents are never streamed
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; forwarding covers a pass that starts on the writing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/circ_smpl_queue.sv
// Circular queue of the latest DEPTH samples, streamed oldest-first in a pass.
// Pass output starts the cycle after the pass begins, one sample per cycle, no bubble.
// Writes during a pass are dropped and flagged on overrun; CIRCQ_DECIM_EN adds decim.
module circ_smpl_queue
  import circq_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 1024,
  parameter int AUTO_SEQ = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef CIRCQ_DECIM_EN
  input  logic [3:0]                   decim,
`endif
  input  logic                         wrt_smpl,
  input  logic [WIDTH-1:0]             new_smpl,
  input  logic                         seq_start,
  output logic                         sequencing,
  output logic [WIDTH-1:0]             smpl_out,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         full,
  output logic                         empty,
  output logic                         overrun
);

  localparam int PW = circq_ptr_w(DEPTH);
  localparam int FW = circq_fill_w(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [FW-1:0] fill_t;

  localparam ptr_t  PTR_LAST = ptr_t'(DEPTH - 1);
  localparam fill_t FILL_MAX = fill_t'(DEPTH);

  // Explicit compare-and-wrap so non power-of-2 depths work
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
  endfunction

  circq_state_t state;
  ptr_t         new_ptr, old_ptr, rd_ptr;
  ptr_t         new_ptr_nxt, old_ptr_nxt, raddr;
  fill_t        fill_r, fill_nxt, remain;
  logic         wr_acc, keep, store, is_full, start, re, overrun_r;

  assign wr_acc = wrt_smpl && (state == IDLE);
  assign store  = wr_acc && keep;

`ifdef CIRCQ_DECIM_EN
  logic [3:0] dcnt, dcnt_eff, decim_q;

  // A change of decim restarts the sequence: the next accepted write is stored
  always_comb begin
    dcnt_eff = (decim != decim_q) ? 4'd0 : dcnt;
  end

  assign keep = (dcnt_eff == 4'd0);

  // Decimation counter over accepted writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt    <= 4'd0;
      decim_q <= 4'd0;
    end else begin
      decim_q <= decim;
      if (wr_acc) dcnt <= (dcnt_eff >= decim) ? 4'd0 : dcnt_eff + 4'd1;
      else        dcnt <= dcnt_eff;
    end
  end
`else
  assign keep = 1'b1;
`endif

  // Post-write pointer/fill values and pass start decision
  always_comb begin
    is_full     = (fill_r == FILL_MAX);
    new_ptr_nxt = new_ptr;
    old_ptr_nxt = old_ptr;
    fill_nxt    = fill_r;
    if (store) begin
      new_ptr_nxt = ptr_inc(new_ptr);
      if (is_full) old_ptr_nxt = ptr_inc(old_ptr);
      else         fill_nxt    = fill_r + fill_t'(1);
    end
    start = 1'b0;
    if (state == IDLE) begin
      if (AUTO_SEQ != 0) start = store && (fill_nxt == FILL_MAX);
      else               start = seq_start && (fill_nxt != '0);
    end
    raddr = (state == IDLE) ? old_ptr_nxt : rd_ptr;
    re    = start || ((state == SEQ) && (remain != fill_t'(1)));
  end

  // Write side: pointers and fill count (untouched by a read-out pass)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr <= '0;
      old_ptr <= '0;
      fill_r  <= '0;
    end else begin
      new_ptr <= new_ptr_nxt;
      old_ptr <= old_ptr_nxt;
      fill_r  <= fill_nxt;
    end
  end

  // Pass sequencer: remain counts the cycles left including the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rd_ptr <= '0;
      remain <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= SEQ;
          remain <= fill_nxt;
          rd_ptr <= ptr_inc(old_ptr_nxt);
        end
        SEQ: begin
          rd_ptr <= ptr_inc(rd_ptr);
          remain <= remain - fill_t'(1);
          if (remain == fill_t'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Dropped-write flag, one cycle after the dropped strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_r <= 1'b0;
    else        overrun_r <= wrt_smpl && (state == SEQ);
  end

  circq_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (store),
    .waddr (new_ptr),
    .wdata (new_smpl),
    .re    (re),
    .raddr (raddr),
    .rdata (smpl_out)
  );

  assign sequencing = (state == SEQ);
  assign fill       = fill_r;
  assign full       = (fill_r == FILL_MAX);
  assign empty      = (fill_r == '0);
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_circ_smpl_queue.sv
// Bench for circ_smpl_queue: DEPTH=8 manual, DEPTH=8 auto, DEPTH=1024 auto.
// Reference model is a sample queue plus a snapshot list for the running pass.
// Decimation scenario is included when CIRCQ_DECIM_EN is defined.
module tb_circ_smpl_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_s = 1'b0;
  logic        start_s = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  decim_s = 4'd0;
  int          cur = 0;
  int          cyc = 0;

  logic        seq0, seq1, seq2, full0, full1, full2, emp0, emp1, emp2, ovr0, ovr1, ovr2;
  logic [15:0] smp0, smp1, smp2;
  logic [3:0]  fil0, fil1;
  logic [10:0] fil2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  circ_smpl_queue #(.WIDTH(16), .DEPTH(8), .AUTO_SEQ(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef CIRCQ_DECIM_EN
    .decim(decim_s),
`endif
    .wrt_smpl(wr_s && cur == 0), .new_smpl(din), .seq_start(start_s && cur == 0),
    .sequencing(seq0), .smpl_out(smp0), .fill(fil0), .full(full0), .empty(emp0), .overrun(ovr0));

  circ_smpl_queue #(.WIDTH(16), .DEPTH(8), .AUTO_SEQ(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef CIRCQ_DECIM_EN
    .decim(decim_s),
`endif
    .wrt_smpl(wr_s && cur == 1), .new_smpl(din), .seq_start(start_s && cur == 1),
    .sequencing(seq1), .smpl_out(smp1), .fill(fil1), .full(full1), .empty(emp1), .overrun(ovr1));

  circ_smpl_queue #(.WIDTH(16), .DEPTH(1024), .AUTO_SEQ(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef CIRCQ_DECIM_EN
    .decim(decim_s),
`endif
    .wrt_smpl(wr_s && cur == 2), .new_smpl(din), .seq_start(start_s && cur == 2),
    .sequencing(seq2), .smpl_out(smp2), .fill(fil2), .full(full2), .empty(emp2), .overrun(ovr2));

  // Outputs of the instance under test
  logic        o_seq, o_full, o_emp, o_ovr;
  logic [15:0] o_smpl;
  int          o_fill;
  always_comb begin
    o_seq = seq0; o_smpl = smp0; o_fill = int'(fil0); o_full = full0; o_emp = emp0; o_ovr = ovr0;
    if (cur == 1) begin
      o_seq = seq1; o_smpl = smp1; o_fill = int'(fil1); o_full = full1; o_emp = emp1; o_ovr = ovr1;
    end else if (cur == 2) begin
      o_seq = seq2; o_smpl = smp2; o_fill = int'(fil2); o_full = full2; o_emp = emp2; o_ovr = ovr2;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, cycle %0d)", tag, obs, exp, cur, cyc);
    end
  endtask

  // Reference model
  logic [15:0] mq[$];
  logic [15:0] mp[$];
  int          m_idx = 0;
  bit          m_act = 0;
  logic [15:0] m_smpl = '0;
  bit          m_ovr = 0;
  int          m_acc = 0;
  int          depth = 8;
  bit          autos = 0;

  task automatic model_reset();
    mq.delete(); mp.delete();
    m_idx = 0; m_act = 0; m_smpl = '0; m_ovr = 0; m_acc = 0;
  endtask

  task automatic check_all();
    chk("sequencing", o_seq, m_act);
    chk("smpl_out", o_smpl, m_smpl);
    chk("fill", o_fill, mq.size());
    chk("full", o_full, mq.size() == depth);
    chk("empty", o_emp, mq.size() == 0);
    chk("overrun", o_ovr, m_ovr);
  endtask

  task automatic step(input bit w, input logic [15:0] d, input bit s);
    wr_s = w; din = d; start_s = s;
    @(posedge clk);
    if (m_act) begin
      m_ovr = w;
      m_idx++;
      if (m_idx == mp.size()) m_act = 0;
      else m_smpl = mp[m_idx];
    end else begin
      bit stored;
      stored = 0;
      m_ovr = 0;
      if (w) begin
        stored = (m_acc % (int'(decim_s) + 1)) == 0;
        m_acc++;
      end
      if (stored) begin
        mq.push_back(d);
        if (mq.size() > depth) void'(mq.pop_front());
      end
      if (autos ? (stored && mq.size() == depth) : (s && mq.size() > 0)) begin
        mp = mq; m_idx = 0; m_act = 1; m_smpl = mp[0];
      end
    end
    #1;
    wr_s = 0; start_s = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0);
  endtask

  // Asynchronous reset: checked immediately and again after a held edge
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic select(input int id, input int d, input bit a);
    cur = id; depth = d; autos = a;
    do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Manual start, DEPTH=8
    select(0, 8, 0);
    idle(2);
    step(0, '0, 1);                                  // start while empty: ignored
    for (int i = 0; i < 8; i++) step(1, 16'(i), 0);
    step(0, '0, 1);
    idle(10);
    for (int i = 8; i < 12; i++) step(1, 16'(i), 0);
    step(1, 16'd12, 1);                              // same-edge write joins the pass
    step(1, 16'd13, 0);                              // dropped -> overrun
    idle(10);
    step(0, '0, 1);
    idle(10);
    do_reset();
    step(1, 16'h00aa, 1);                            // single-entry pass on the writing edge
    idle(3);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 7) == 0);
    idle(12);
    step(0, '0, 1);
    idle(3);
    do_reset();                                      // reset mid-pass
    idle(2);

    // Automatic start, DEPTH=8
    select(1, 8, 1);
    for (int i = 0; i < 8; i++) step(1, 16'(i), 0);
    idle(10);
    step(1, 16'd8, 0);
    idle(2);
    step(1, 16'd9, 0);                               // dropped mid-pass
    idle(8);
    step(1, 16'd10, 0);
    idle(10);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) == 0, 16'($urandom), 1'($urandom_range(0, 1)));
    idle(10);

    // Automatic start, DEPTH=1024
    select(2, 1024, 1);
    for (int i = 0; i < 1024; i++) step(1, 16'(i), 0);
    idle(1030);

`ifdef CIRCQ_DECIM_EN
    decim_s = 4'd2;
    select(0, 8, 0);
    for (int i = 0; i < 24; i++) step(1, 16'(i), 0);
    step(0, '0, 1);
    idle(10);
    decim_s = 4'd0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
